// File: rtl/ctrl_unit_pipe.sv
// MIPS control unit: two-stage decode pipeline (D: raw word, E: bundle)
// with valid/ready flow control, load-use bubble insertion and flush.
package ctrl_unit_pipe_pkg;
  typedef struct packed {
    logic        reg_dst;
    logic        alu_src_a;
    logic        alu_src_b;
    logic [1:0]  datato_reg;
    logic        jal;
    logic [1:0]  branch;
    logic        reg_write;
    logic [2:0]  alu_ctrl;
    logic        mem_w;
    logic [25:0] inst_field;
  } id_ex_t;
endpackage

module ctrl_unit_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_in,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic        flush,
  input  logic        ctrl_ready,
  output logic        ctrl_valid,
  output logic        RegDst,
  output logic        ALUSrc_A,
  output logic        ALUSrc_B,
  output logic [1:0]  DatatoReg,
  output logic        Jal,
  output logic [1:0]  Branch,
  output logic        RegWrite,
  output logic [2:0]  ALU_Control,
  output logic        mem_w,
  output logic [25:0] inst_field,
  output logic        illegal
);
  import ctrl_unit_pipe_pkg::*;

  logic [31:0] d_inst;
  logic        d_valid;
  id_ex_t      e_q;
  id_ex_t      dec;
  logic        dec_ill;
  logic        e_load;
  logic        hazard;
  logic        d_advance;
  logic [5:0]  op;
  logic [5:0]  fn;
  logic        rt;
  logic [4:0]  e_rt;

  assign op   = d_inst[31:26];
  assign fn   = d_inst[5:0];
  assign rt   = (op == 6'h00);
  assign e_rt = e_q.inst_field[20:16];

  // only lw carries DatatoReg=01, so this identifies a pending load
  assign hazard = d_valid && ctrl_valid
               && (e_q.datato_reg == 2'b01)
               && (e_rt != 5'd0)
               && ((e_rt == d_inst[25:21])
                || (e_rt == d_inst[20:16]));

  assign e_load     = !ctrl_valid || ctrl_ready;
  assign d_advance  = d_valid && e_load && !hazard;
  assign inst_ready = !d_valid || d_advance;

  always_comb begin
    dec     = '0;
    dec_ill = 1'b0;
    unique case (1'b1)
      rt && fn == 6'h20: begin
        dec.reg_dst = 1'b1; dec.reg_write = 1'b1;
        dec.alu_ctrl = 3'b010;
      end
      rt && fn == 6'h22: begin
        dec.reg_dst = 1'b1; dec.reg_write = 1'b1;
        dec.alu_ctrl = 3'b110;
      end
      rt && fn == 6'h24: begin
        dec.reg_dst = 1'b1; dec.reg_write = 1'b1;
        dec.alu_ctrl = 3'b000;
      end
      rt && fn == 6'h25: begin
        dec.reg_dst = 1'b1; dec.reg_write = 1'b1;
        dec.alu_ctrl = 3'b001;
      end
      rt && fn == 6'h26: begin
        dec.reg_dst = 1'b1; dec.reg_write = 1'b1;
        dec.alu_ctrl = 3'b011;
      end
      rt && fn == 6'h27: begin
        dec.reg_dst = 1'b1; dec.reg_write = 1'b1;
        dec.alu_ctrl = 3'b100;
      end
      rt && fn == 6'h2A: begin
        dec.reg_dst = 1'b1; dec.reg_write = 1'b1;
        dec.alu_ctrl = 3'b111;
      end
      rt && fn == 6'h02: begin
        dec.reg_dst = 1'b1; dec.reg_write = 1'b1;
        dec.alu_src_a = 1'b1; dec.alu_src_b = 1'b1;
        dec.alu_ctrl = 3'b101;
      end
      rt && fn == 6'h08: begin
        dec.reg_dst = 1'b1; dec.branch = 2'b11;
      end
      rt && fn == 6'h09: begin
        dec.reg_dst = 1'b1; dec.datato_reg = 2'b11;
        dec.jal = 1'b1; dec.branch = 2'b11;
        dec.reg_write = 1'b1;
      end
      op == 6'h08: begin
        dec.alu_src_b = 1'b1; dec.reg_write = 1'b1;
        dec.alu_ctrl = 3'b010;
      end
      op == 6'h0D: begin
        dec.alu_src_b = 1'b1; dec.reg_write = 1'b1;
        dec.alu_ctrl = 3'b001;
      end
      op == 6'h0C: begin
        dec.alu_src_b = 1'b1; dec.reg_write = 1'b1;
        dec.alu_ctrl = 3'b000;
      end
      op == 6'h0E: begin
        dec.alu_src_b = 1'b1; dec.reg_write = 1'b1;
        dec.alu_ctrl = 3'b011;
      end
      op == 6'h0A: begin
        dec.alu_src_b = 1'b1; dec.reg_write = 1'b1;
        dec.alu_ctrl = 3'b111;
      end
      op == 6'h0F: begin
        dec.alu_src_b = 1'b1; dec.reg_write = 1'b1;
        dec.datato_reg = 2'b10;
      end
      op == 6'h23: begin
        dec.alu_src_b = 1'b1; dec.reg_write = 1'b1;
        dec.datato_reg = 2'b01; dec.alu_ctrl = 3'b010;
      end
      op == 6'h2B: begin
        dec.alu_src_b = 1'b1; dec.mem_w = 1'b1;
        dec.alu_ctrl = 3'b010;
      end
      op == 6'h04 || op == 6'h05: begin
        dec.branch = 2'b01; dec.alu_ctrl = 3'b110;
      end
      op == 6'h02: dec.branch = 2'b10;
      op == 6'h03: begin
        dec.datato_reg = 2'b11; dec.jal = 1'b1;
        dec.branch = 2'b10; dec.reg_write = 1'b1;
      end
      default: dec_ill = 1'b1;
    endcase
    if (!dec_ill) dec.inst_field = d_inst[25:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_inst  <= '0;
      d_valid <= 1'b0;
    end else if (flush) begin
      d_valid <= 1'b0;
    end else if (inst_valid && inst_ready) begin
      d_inst  <= inst_in;
      d_valid <= 1'b1;
    end else if (d_advance) begin
      d_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_q        <= '0;
      ctrl_valid <= 1'b0;
      illegal    <= 1'b0;
    end else if (flush) begin
      e_q        <= '0;
      ctrl_valid <= 1'b0;
    end else if (e_load) begin
      if (d_advance) begin
        e_q        <= dec;
        ctrl_valid <= 1'b1;
        if (dec_ill) illegal <= 1'b1;
      end else if (hazard) begin
        e_q        <= '0;
        ctrl_valid <= 1'b1;
      end else begin
        ctrl_valid <= 1'b0;
      end
    end
  end

  assign RegDst      = e_q.reg_dst;
  assign ALUSrc_A    = e_q.alu_src_a;
  assign ALUSrc_B    = e_q.alu_src_b;
  assign DatatoReg   = e_q.datato_reg;
  assign Jal         = e_q.jal;
  assign Branch      = e_q.branch;
  assign RegWrite    = e_q.reg_write;
  assign ALU_Control = e_q.alu_ctrl;
  assign mem_w       = e_q.mem_w;
  assign inst_field  = e_q.inst_field;
endmodule

// File: tb/tb_ctrl_unit_pipe.sv
// Bench for ctrl_unit_pipe: directed scenarios plus randomized traffic
// against a slot-level reference model with a mnemonic-table decoder.
module tb_ctrl_unit_pipe;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] inst_in = '0;
  logic        inst_valid = 1'b0;
  logic        inst_ready;
  logic        flush = 1'b0;
  logic        ctrl_ready = 1'b0;
  logic        ctrl_valid;
  logic        RegDst, ALUSrc_A, ALUSrc_B, Jal, RegWrite, mem_w;
  logic [1:0]  DatatoReg, Branch;
  logic [2:0]  ALU_Control;
  logic [25:0] inst_field;
  logic        illegal;
  logic [38:0] dut_b;

  ctrl_unit_pipe dut (
    .clk(clk), .rst(rst),
    .inst_in(inst_in), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .flush(flush),
    .ctrl_ready(ctrl_ready), .ctrl_valid(ctrl_valid),
    .RegDst(RegDst), .ALUSrc_A(ALUSrc_A),
    .ALUSrc_B(ALUSrc_B), .DatatoReg(DatatoReg),
    .Jal(Jal), .Branch(Branch), .RegWrite(RegWrite),
    .ALU_Control(ALU_Control), .mem_w(mem_w),
    .inst_field(inst_field), .illegal(illegal)
  );

  always #5 clk = ~clk;

  assign dut_b = {RegDst, ALUSrc_A, ALUSrc_B, DatatoReg, Jal,
                  Branch, RegWrite, ALU_Control, mem_w, inst_field};

  int n_pass = 0;
  int n_total = 0;

  // model: "waiting" word not yet decoded, "shown" bundle on the outputs
  logic [31:0] w_inst = '0;
  bit          w_full = 0;
  bit          s_full = 0;
  logic [38:0] s_bundle = '0;
  logic [4:0]  s_lw_rt = '0;
  bit          s_ill = 0;

  logic [5:0] rfn [10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26,
                           6'h27, 6'h2A, 6'h02, 6'h08, 6'h09};
  logic [5:0] iop [12] = '{6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0A, 6'h0F,
                           6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};

  localparam logic [31:0] ADD0 = 32'h00004020;
  localparam logic [31:0] ORI  = 32'h35281234;
  localparam logic [31:0] SLT  = 32'h012A582A;
  localparam logic [31:0] SUB  = 32'h01CF6822;
  localparam logic [31:0] LUI  = 32'h3C10ABCD;
  localparam logic [31:0] JAL1 = 32'h0C100000;
  localparam logic [31:0] JAL2 = 32'h0C000040;
  localparam logic [31:0] LW   = 32'h8D2A0000;
  localparam logic [31:0] OR4  = 32'h012A6025;
  localparam logic [31:0] BAD  = 32'hFC000000;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
  endtask

  // returns {illegal, bundle}
  function automatic logic [39:0] ref_dec(input logic [31:0] w);
    string m;
    logic rd, a, b, jl, rw, mw;
    logic [1:0] dtr, br;
    logic [2:0] alu;
    m = "bad";
    {rd, a, b, jl, rw, mw, dtr, br, alu} = '0;
    if (w[31:26] == 6'h00) begin
      case (w[5:0])
        6'h20: m = "add";  6'h22: m = "sub";
        6'h24: m = "and";  6'h25: m = "or";
        6'h26: m = "xor";  6'h27: m = "nor";
        6'h2A: m = "slt";  6'h02: m = "srl";
        6'h08: m = "jr";   6'h09: m = "jalr";
        default: m = "bad";
      endcase
    end else begin
      case (w[31:26])
        6'h08: m = "addi"; 6'h0C: m = "andi";
        6'h0D: m = "ori";  6'h0E: m = "xori";
        6'h0A: m = "slti"; 6'h0F: m = "lui";
        6'h23: m = "lw";   6'h2B: m = "sw";
        6'h04: m = "beq";  6'h05: m = "bne";
        6'h02: m = "j";    6'h03: m = "jal";
        default: m = "bad";
      endcase
    end
    case (m)
      "add":  begin rd = 1; rw = 1; alu = 3'b010; end
      "sub":  begin rd = 1; rw = 1; alu = 3'b110; end
      "and":  begin rd = 1; rw = 1; alu = 3'b000; end
      "or":   begin rd = 1; rw = 1; alu = 3'b001; end
      "xor":  begin rd = 1; rw = 1; alu = 3'b011; end
      "nor":  begin rd = 1; rw = 1; alu = 3'b100; end
      "slt":  begin rd = 1; rw = 1; alu = 3'b111; end
      "srl":  begin rd = 1; a = 1; b = 1; rw = 1; alu = 3'b101; end
      "jr":   begin rd = 1; br = 2'b11; end
      "jalr": begin rd = 1; dtr = 2'b11; jl = 1; br = 2'b11; rw = 1; end
      "addi": begin b = 1; rw = 1; alu = 3'b010; end
      "andi": begin b = 1; rw = 1; alu = 3'b000; end
      "ori":  begin b = 1; rw = 1; alu = 3'b001; end
      "xori": begin b = 1; rw = 1; alu = 3'b011; end
      "slti": begin b = 1; rw = 1; alu = 3'b111; end
      "lui":  begin b = 1; rw = 1; dtr = 2'b10; end
      "lw":   begin b = 1; rw = 1; dtr = 2'b01; alu = 3'b010; end
      "sw":   begin b = 1; mw = 1; alu = 3'b010; end
      "beq", "bne": begin br = 2'b01; alu = 3'b110; end
      "j":    br = 2'b10;
      "jal":  begin dtr = 2'b11; jl = 1; br = 2'b10; rw = 1; end
      default: ;
    endcase
    if (m == "bad") return {1'b1, 39'd0};
    return {1'b0, rd, a, b, dtr, jl, br, rw, alu, mw, w[25:0]};
  endfunction

  task automatic step(bit v, logic [31:0] i, bit r, bit f);
    bit out_free, stall_lu, moves, rdy_exp;
    logic [39:0] d;
    @(negedge clk);
    inst_valid = v; inst_in = i; ctrl_ready = r; flush = f;
    #1;
    out_free = !s_full || r;
    stall_lu = w_full && s_full && s_lw_rt != 0
            && (s_lw_rt == w_inst[25:21] || s_lw_rt == w_inst[20:16]);
    moves   = w_full && out_free && !stall_lu;
    rdy_exp = !w_full || moves;
    check("inst_ready", inst_ready, rdy_exp);
    check("ctrl_valid", ctrl_valid, s_full);
    check("illegal", illegal, s_ill);
    if (s_full) check("bundle", dut_b, s_bundle);
    @(posedge clk);
    if (f) begin
      w_full = 0; s_full = 0; s_lw_rt = 0;
    end else begin
      if (out_free) begin
        if (moves) begin
          d = ref_dec(w_inst);
          s_bundle = d[38:0]; s_full = 1;
          if (d[39]) s_ill = 1;
          s_lw_rt = (w_inst[31:26] == 6'h23) ? w_inst[20:16] : 5'd0;
        end else if (stall_lu) begin
          s_bundle = '0; s_full = 1; s_lw_rt = 0;
        end else begin
          s_full = 0; s_lw_rt = 0;
        end
      end
      if (v && rdy_exp) begin
        w_inst = i; w_full = 1;
      end else if (moves) begin
        w_full = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0; inst_valid = 0; flush = 0; ctrl_ready = 0;
    #1;
    w_full = 0; s_full = 0; s_lw_rt = 0; s_ill = 0; s_bundle = '0;
    check("rst_ctrl_valid", ctrl_valid, 0);
    check("rst_illegal", illegal, 0);
    check("rst_bundle", dut_b, 0);
    repeat (2) @(negedge clk);
    rst = 1;
    #1;
    check("rst_inst_ready", inst_ready, 1);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [4:0] rs, rt_, rd;
    rs = 5'($urandom_range(0, 3));
    rt_ = 5'($urandom_range(0, 3));
    rd = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 3))
      0: w = {6'h00, rs, rt_, rd, 5'($urandom), rfn[$urandom_range(0, 9)]};
      1, 2: w = {iop[$urandom_range(0, 11)], rs, rt_, 16'($urandom)};
      default:
        if ($urandom_range(0, 3) == 0) w = $urandom;
        else w = {6'h23, rs, rt_, 16'($urandom)};
    endcase
    return w;
  endfunction

  initial begin
    do_reset();

    // single add, two-cycle latency
    step(1, ADD0, 1, 0);
    check("add_lat1_valid", ctrl_valid, 0);
    step(0, 0, 1, 0);
    check("add_valid", ctrl_valid, 1);
    check("add_bundle", dut_b,
          {1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 3'b010,
           1'b0, 26'h0004020});
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);

    // back-to-back stream
    step(1, ORI, 1, 0);
    step(1, SLT, 1, 0);
    step(1, SUB, 1, 0);
    step(1, LUI, 1, 0);
    step(1, JAL1, 1, 0);
    check("lui_dtr", DatatoReg, 2'b10);
    check("lui_srcb", ALUSrc_B, 1);
    step(1, JAL2, 1, 0);
    check("jal_ctl", {DatatoReg, Jal, Branch, RegWrite},
          {2'b11, 1'b1, 2'b10, 1'b1});
    check("jal_field", inst_field, 26'h0100000);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);

    // load-use bubble
    step(1, LW, 1, 0);
    step(1, OR4, 1, 0);
    check("lu_ready_low", inst_ready, 0);
    step(0, 0, 1, 0);
    check("bubble_valid", ctrl_valid, 1);
    check("bubble_zero", dut_b, 0);
    check("bubble_ready", inst_ready, 1);
    step(0, 0, 1, 0);
    check("or_bundle", dut_b,
          {1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 3'b001,
           1'b0, 26'h12A6025});
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);

    // backpressure for three cycles
    step(1, ADD0, 0, 0);
    step(1, ORI, 0, 0);
    check("stall_ready", inst_ready, 0);
    step(1, SUB, 0, 0);
    step(1, SUB, 0, 0);
    check("stall_hold", dut_b,
          {1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 3'b010,
           1'b0, 26'h0004020});
    check("stall_ready2", inst_ready, 0);
    step(0, 0, 1, 0);
    check("release_ori", {ALUSrc_B, ALU_Control, inst_field},
          {1'b1, 3'b001, 26'h1281234});
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);

    // flush with both stages full
    step(1, ADD0, 1, 0);
    step(1, ORI, 1, 0);
    step(1, SUB, 1, 1);
    check("flush_valid", ctrl_valid, 0);
    check("flush_ready", inst_ready, 1);
    step(0, 0, 1, 0);
    check("flush_empty", ctrl_valid, 0);

    // illegal opcode 0x3F
    step(1, BAD, 1, 0);
    step(0, 0, 1, 0);
    check("ill_valid", ctrl_valid, 1);
    check("ill_zero", dut_b, 0);
    check("ill_flag", illegal, 1);
    repeat (3) step(0, 0, 1, 0);
    check("ill_sticky", illegal, 1);

    // random traffic with occasional reset
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      step($urandom_range(0, 3) != 0, rand_inst(),
           $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
    end

    // reset mid-operation discards in-flight work
    step(1, ADD0, 1, 0);
    step(1, ORI, 1, 0);
    do_reset();
    step(0, 0, 1, 0);
    check("post_rst_empty", ctrl_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
